uart_cmd_decoder: RTL and testbench

Decodes command bytes from the home-automation UART receiver into registered control state and returns acknowledge and status bytes toward the UART transmitter. Sits between `uart_rx` (upstream, byte + valid pulse) and `uart_tx` (downstream, valid/ready byte handshake) inside `home_automation`. Each command byte is `{opcode[7:4], arg[3:0]}`. The block drives the eco-mode, AC-mode, blinds-override and occupancy inputs of the control logic.

---
 rtl/uart_cmd_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Turns command bytes from uart_rx ({opcode[7:4], arg[3:0]}) into registered
//   control state for the home-automation logic. Response bytes go back to
//   uart_tx over a valid/ready handshake.
//
//   Optional feature macro: UART_CMD_ACK_EN
//     defined   : every non-status command is answered with an ack byte
//                 {opcode,4'h0}, or 8'hEE for an unknown opcode.
//     undefined : only status queries (opcode 0xF) produce transmit traffic.
//
//   Ports
//     clk, reset        : system clock, synchronous active-high reset
//     rx_data_i/valid_i : received byte plus a one-cycle strobe
//     tx_data_o/valid_o : response byte toward the transmitter
//     tx_ready_i        : the transmitter takes the byte when valid & ready
//     eco_mode_o, ac_mode_o, blinds_ovr_en_o, blinds_ovr_val_o,
//     person_count_o    : registered control state
//     cmd_error_o       : one-cycle pulse on an unknown opcode
//     resp_drop_o       : one-cycle pulse when a response cannot be queued
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | no response pending
//   ST_ACK     | ack/nak byte offered (UART_CMD_ACK_EN builds only)
//   ST_STAT0   | status byte 0 offered (mode flags)
//   ST_STAT1   | status byte 1 offered (person count)
module uart_cmd_decoder #(
   parameter int MAX_PERSONS = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic       eco_mode_o,
   output logic [1:0] ac_mode_o,
   output logic       blinds_ovr_en_o,
   output logic       blinds_ovr_val_o,
   output logic [7:0] person_count_o,
   output logic       cmd_error_o,
   output logic       resp_drop_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef UART_CMD_ACK_EN
   localparam logic [1:0] ST_ACK   = 2'd1;
`endif
   localparam logic [1:0] ST_STAT0 = 2'd2;
   localparam logic [1:0] ST_STAT1 = 2'd3;

   localparam logic [3:0] OP_ECO    = 4'h0;
   localparam logic [3:0] OP_AC     = 4'hA;
   localparam logic [3:0] OP_BLINDS = 4'hB;
   localparam logic [3:0] OP_COUNT  = 4'hC;
   localparam logic [3:0] OP_STAT   = 4'hF;

   localparam logic [9:0] MAX_CNT = 10'(MAX_PERSONS);

   logic [1:0] state_q, state_d;
   logic       eco_q, eco_d;
   logic [1:0] ac_q, ac_d;
   logic       ovr_en_q, ovr_en_d;
   logic       ovr_val_q, ovr_val_d;
   logic [7:0] count_q, count_d;
   logic       err_q, err_d;
   logic       drop_q, drop_d;
   logic [7:0] stat0_q, stat0_d;
   logic [7:0] stat1_q, stat1_d;
`ifdef UART_CMD_ACK_EN
   logic [7:0] ack_q, ack_d;
`endif

   logic [3:0] op, arg;
   logic [9:0] sum;
   logic [7:0] count_sat;
   logic       unknown_op;
   logic       hs;

   assign op  = rx_data_i[7:4];
   assign arg = rx_data_i[3:0];
   assign hs  = tx_valid_o & tx_ready_i;

   // Signed delta is sign-extended to 10 bits, so an underflow shows up as bit 9.
   assign sum = {2'b00, count_q} + {{6{arg[3]}}, arg};

   always_comb begin
      if (sum[9])             count_sat = 8'd0;
      else if (sum > MAX_CNT) count_sat = MAX_CNT[7:0];
      else                    count_sat = sum[7:0];
   end

   always_comb begin
      unknown_op = 1'b0;
      case (op)
         OP_ECO, OP_AC, OP_BLINDS, OP_COUNT, OP_STAT: unknown_op = 1'b0;
         default:                                     unknown_op = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      eco_d     = eco_q;
      ac_d      = ac_q;
      ovr_en_d  = ovr_en_q;
      ovr_val_d = ovr_val_q;
      count_d   = count_q;
      err_d     = 1'b0;
      drop_d    = 1'b0;
      stat0_d   = stat0_q;
      stat1_d   = stat1_q;
`ifdef UART_CMD_ACK_EN
      ack_d     = ack_q;
`endif

      if (hs) begin
         case (state_q)
            ST_STAT0: state_d = ST_STAT1;
            default:  state_d = ST_IDLE;
         endcase
      end

      // Control state follows every byte; only the response depends on the FSM.
      if (rx_valid_i) begin
         case (op)
            OP_ECO:    eco_d = arg[0];
            OP_AC:     ac_d  = arg[1:0];
            OP_BLINDS: begin
               ovr_en_d  = arg[0];
               ovr_val_d = arg[1];
            end
            OP_COUNT:  count_d = count_sat;
            default:   ;
         endcase
         err_d = unknown_op;

         // A byte on the final-handshake edge still sees a busy state and is dropped.
         if (state_q != ST_IDLE) begin
            drop_d = 1'b1;
         end else if (op == OP_STAT) begin
            state_d = ST_STAT0;
            stat0_d = {eco_q, ac_q, ovr_en_q, ovr_val_q, 3'b000};
            stat1_d = count_q;
         end
`ifdef UART_CMD_ACK_EN
         else begin
            state_d = ST_ACK;
            ack_d   = unknown_op ? 8'hEE : {op, 4'h0};
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         eco_q     <= 1'b0;
         ac_q      <= 2'b00;
         ovr_en_q  <= 1'b0;
         ovr_val_q <= 1'b0;
         count_q   <= 8'd0;
         err_q     <= 1'b0;
         drop_q    <= 1'b0;
         stat0_q   <= 8'd0;
         stat1_q   <= 8'd0;
`ifdef UART_CMD_ACK_EN
         ack_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         eco_q     <= eco_d;
         ac_q      <= ac_d;
         ovr_en_q  <= ovr_en_d;
         ovr_val_q <= ovr_val_d;
         count_q   <= count_d;
         err_q     <= err_d;
         drop_q    <= drop_d;
         stat0_q   <= stat0_d;
         stat1_q   <= stat1_d;
`ifdef UART_CMD_ACK_EN
         ack_q     <= ack_d;
`endif
      end
   end

   always_comb begin
      tx_data_o = 8'd0;
      case (state_q)
         ST_STAT0: tx_data_o = stat0_q;
         ST_STAT1: tx_data_o = stat1_q;
`ifdef UART_CMD_ACK_EN
         ST_ACK:   tx_data_o = ack_q;
`endif
         default:  tx_data_o = 8'd0;
      endcase
   end

   assign tx_valid_o       = (state_q != ST_IDLE);
   assign eco_mode_o       = eco_q;
   assign ac_mode_o        = ac_q;
   assign blinds_ovr_en_o  = ovr_en_q;
   assign blinds_ovr_val_o = ovr_val_q;
   assign person_count_o   = count_q;
   assign cmd_error_o      = err_q;
   assign resp_drop_o      = drop_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i;
   logic       eco_mode_o;
   logic [1:0] ac_mode_o;
   logic       blinds_ovr_en_o;
   logic       blinds_ovr_val_o;
   logic [7:0] person_count_o;
   logic       cmd_error_o;
   logic       resp_drop_o;

   int checks   = 0;
   int failures = 0;

   uart_cmd_decoder #(.MAX_PERSONS(200)) dut (
      .clk              (clk),
      .reset            (reset),
      .rx_data_i        (rx_data_i),
      .rx_valid_i       (rx_valid_i),
      .tx_data_o        (tx_data_o),
      .tx_valid_o       (tx_valid_o),
      .tx_ready_i       (tx_ready_i),
      .eco_mode_o       (eco_mode_o),
      .ac_mode_o        (ac_mode_o),
      .blinds_ovr_en_o  (blinds_ovr_en_o),
      .blinds_ovr_val_o (blinds_ovr_val_o),
      .person_count_o   (person_count_o),
      .cmd_error_o      (cmd_error_o),
      .resp_drop_o      (resp_drop_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; return 1 ns after it so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Byte presented for exactly one active edge; returns in cycle N+1.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      @(posedge clk);
      #1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
   endtask

   // Command followed by one idle cycle, so any ack handshakes before the next byte.
   task automatic send_idle(input logic [7:0] b);
      send(b);
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      rx_data_i  = 8'h00;
      rx_valid_i = 1'b0;
      tx_ready_i = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      chk("rst_eco",   eco_mode_o, 0);
      chk("rst_ac",    ac_mode_o, 0);
      chk("rst_ovr",   {blinds_ovr_en_o, blinds_ovr_val_o}, 0);
      chk("rst_count", person_count_o, 0);
      chk("rst_valid", tx_valid_o, 0);
      chk("rst_data",  tx_data_o, 0);
      chk("rst_err",   cmd_error_o, 0);
      chk("rst_drop",  resp_drop_o, 0);

      tx_ready_i = 1'b1;

      // Basic commands: 0x01, 0xA3, 0xC7, 0xCE
      send(8'h01);
      chk("eco_set", eco_mode_o, 1);
`ifdef UART_CMD_ACK_EN
      chk("ack01_valid", tx_valid_o, 1);
      chk("ack01_data",  tx_data_o, 8'h00);
`else
      chk("noack01_valid", tx_valid_o, 0);
`endif
      tick();
      chk("ack01_done", tx_valid_o, 0);

      send(8'hA3);
      chk("ac_set", ac_mode_o, 3);
`ifdef UART_CMD_ACK_EN
      chk("ackA3_data", tx_data_o, 8'hA0);
`else
      chk("noackA3_valid", tx_valid_o, 0);
`endif
      tick();

      send(8'hC7);
      chk("count_p7", person_count_o, 7);
`ifdef UART_CMD_ACK_EN
      chk("ackC7_data", tx_data_o, 8'hC0);
`endif
      tick();

      send(8'hCE);
      chk("count_m2", person_count_o, 5);
      chk("count_drop0", resp_drop_o, 0);
`ifdef UART_CMD_ACK_EN
      chk("ackCE_data", tx_data_o, 8'hC0);
`endif
      tick();

      // Lower clamp: 5-8 -> 0, then 0-8 -> 0
      send_idle(8'hC8);
      chk("clamp_lo_a", person_count_o, 0);
      send_idle(8'hC8);
      chk("clamp_lo_b", person_count_o, 0);

      // Upper clamp: reach 197 (= 28*7 + 1), then +7 -> 200, then +7 stays 200
      for (int i = 0; i < 28; i++) send_idle(8'hC7);
      send_idle(8'hC1);
      chk("count_197", person_count_o, 197);
      send_idle(8'hC7);
      chk("clamp_hi_a", person_count_o, 200);
      send_idle(8'hC7);
      chk("clamp_hi_b", person_count_o, 200);

      // Unknown opcode
      send(8'h55);
      chk("err_pulse", cmd_error_o, 1);
      chk("err_eco",   eco_mode_o, 1);
      chk("err_ac",    ac_mode_o, 3);
      chk("err_count", person_count_o, 200);
`ifdef UART_CMD_ACK_EN
      chk("nak_valid", tx_valid_o, 1);
      chk("nak_data",  tx_data_o, 8'hEE);
`else
      chk("nak_none",  tx_valid_o, 0);
`endif
      tick();
      chk("err_clear", cmd_error_o, 0);
      chk("nak_done",  tx_valid_o, 0);

      // Build state eco=1 ac=2 ovr=1/1 count=5
      send_idle(8'hA2);
      send_idle(8'hB3);
      for (int i = 0; i < 26; i++) send_idle(8'hC8);
      send_idle(8'hC5);
      chk("pre_stat_count", person_count_o, 5);

      // Status query with ready low for 4 cycles
      tx_ready_i = 1'b0;
      send(8'hF0);
      chk("stat0_valid", tx_valid_o, 1);
      chk("stat0_data",  tx_data_o, 8'hD8);
      chk("stat_err",    cmd_error_o, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stat0_hold_valid", tx_valid_o, 1);
         chk("stat0_hold_data",  tx_data_o, 8'hD8);
      end
      tx_ready_i = 1'b1;
      tick();
      tx_ready_i = 1'b0;
      chk("stat1_valid", tx_valid_o, 1);
      chk("stat1_data",  tx_data_o, 8'h05);

      // Bytes during STAT1 are applied and dropped
      send(8'hB0);
      chk("busy_b0_ovr",  {blinds_ovr_en_o, blinds_ovr_val_o}, 2'b00);
      chk("busy_b0_drop", resp_drop_o, 1);
      chk("busy_b0_data", tx_data_o, 8'h05);
      tick();
      chk("busy_b0_dropclr", resp_drop_o, 0);
      send(8'hB3);
      chk("busy_b3_ovr",  {blinds_ovr_en_o, blinds_ovr_val_o}, 2'b11);
      chk("busy_b3_drop", resp_drop_o, 1);
      chk("busy_b3_data", tx_data_o, 8'h05);
      chk("busy_b3_valid", tx_valid_o, 1);
      tick();
      chk("busy_b3_dropclr", resp_drop_o, 0);

      // Byte on the same edge as the final STAT1 handshake
      tx_ready_i = 1'b1;
      send(8'h00);
      chk("edge_eco",   eco_mode_o, 0);
      chk("edge_drop",  resp_drop_o, 1);
      chk("edge_valid", tx_valid_o, 0);
      tick();
      chk("edge_dropclr", resp_drop_o, 0);

      // Reset in the middle of a status response, with a byte on the same edge
      send_idle(8'h01);
      tx_ready_i = 1'b0;
      send(8'hF0);
      chk("pre_rst_valid", tx_valid_o, 1);
      @(negedge clk);
      reset      = 1'b1;
      rx_data_i  = 8'hA1;
      rx_valid_i = 1'b1;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      chk("mrst_valid", tx_valid_o, 0);
      chk("mrst_data",  tx_data_o, 0);
      chk("mrst_eco",   eco_mode_o, 0);
      chk("mrst_ac",    ac_mode_o, 0);
      chk("mrst_ovr",   {blinds_ovr_en_o, blinds_ovr_val_o}, 0);
      chk("mrst_count", person_count_o, 0);
      chk("mrst_drop",  resp_drop_o, 0);

      tx_ready_i = 1'b1;
      send(8'hF0);
      chk("post_stat0_valid", tx_valid_o, 1);
      chk("post_stat0_data",  tx_data_o, 8'h00);
      tick();
      chk("post_stat1_valid", tx_valid_o, 1);
      chk("post_stat1_data",  tx_data_o, 8'h00);
      tick();
      chk("post_idle", tx_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
